triangle_rasterizer: RTL and testbench
======================================

Name: triangle_rasterizer

Overview:
- Stage directly downstream of the back-face cull stage: accepts one screen-space triangle that passed culling and emits, in row-major order, the integer coordinates of every covered pixel.
- Bounding box is clamped to the screen. Pixel centres are tested against three edge functions.
- Valid/ready handshakes on both the triangle input and the pixel output. Feeds the fragment/depth stage.

Parameters:
- SCREEN_W, 64, screen width in pixels
- SCREEN_H, 64, screen height in pixels
- COORD_BITS, 8, width of pixel coordinate outputs; must hold SCREEN_W-1 and SCREEN_H-1

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_tri_valid  in  1  triangle presented
- o_tri_ready  out  1  block can accept a triangle
- i_v1, i_v2, i_v3  in  Vector4_t each  screen-space vertices; only .x and .y used (FixedPoint_t, 16.16 signed)
- o_pixel_valid  out  1  covered pixel presented
- i_pixel_ready  in  1  downstream accepts pixel
- o_pixel_x  out  COORD_BITS  pixel column
- o_pixel_y  out  COORD_BITS  pixel row
- o_busy  out  1  triangle in progress (not IDLE)
- o_done  out  1  one-cycle pulse: current triangle fully emitted

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-low on i_reset_n.
- Reset values while asserted: state IDLE, o_tri_ready=0, o_pixel_valid=0, o_pixel_x=0, o_pixel_y=0, o_busy=0, o_done=0. First cycle after release: o_tri_ready=1.
- FSM states: IDLE, SETUP, SCAN, DONE.
- IDLE:
  - o_tri_ready=1.
  - On i_tri_valid&&o_tri_ready, latch x/y of all three vertices, go to SETUP.
- SETUP (exactly 1 cycle):
  - Bbox min/max = floor (arithmetic >>16) of vertex min/max, per axis.
  - Clamp min to 0, max to SCREEN_W-1 / SCREEN_H-1.
  - Compute area = (v1-v2).x*(v3-v1).y - (v1-v2).y*(v3-v1).x at full precision.
  - If area==0, or clamped min>max on either axis: go to DONE; no pixels emitted.
  - Otherwise load x=xmin, y=ymin and go to SCAN.
- SCAN:
  - Sample point p = (x<<16 | 0x8000, y<<16 | 0x8000).
  - Edge function for each edge (a,b) in {(v1,v2),(v2,v3),(v3,v1)}: E = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x).
  - Subtractions are 33-bit signed; products and E are 67-bit signed; no truncation or rounding.
  - inside = all E>=0 or all E<=0. This is winding-agnostic and edge-inclusive; no top-left rule.
  - o_pixel_valid = inside (combinational from registered x,y and latched vertices); o_pixel_x/o_pixel_y = x,y.
  - Advance when !inside, or when inside&&i_pixel_ready.
  - Advance rule: x==xmax → x=xmin, y=y+1; else x=x+1.
  - On advance from (xmax,ymax), go to DONE.
  - When inside&&!i_pixel_ready: hold x,y; o_pixel_valid, o_pixel_x and o_pixel_y stay stable.
  - Throughput: one candidate pixel per cycle while unstalled.
- DONE (1 cycle): o_done=1, o_tri_ready=0, then IDLE.
- o_busy=1 in SETUP, SCAN and DONE.
- o_tri_ready=0 outside IDLE. A new triangle cannot be accepted in the same cycle as o_done.
- Minimum latency, accept to first possible pixel: 2 cycles (accept, SETUP, then SCAN).
- Reset mid-operation: triangle abandoned immediately, no o_done, outputs go to reset values.
- Vertices outside the screen, including negative coordinates, are legal and handled by the clamp.

Test Plan:
- Coverage count: v1=(0,0), v2=(4,0), v3=(0,4), ready always 1 → exactly 10 pixels in order (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(0,2),(1,2),(0,3); o_done pulses once, 1 cycle after the pixel (4,4) is scanned; o_tri_ready returns 1 the next cycle.
- Backpressure: same triangle with i_pixel_ready=0 for the first 5 cycles of valid → o_pixel_valid=1 and (0,0) held stable all 5 cycles; still exactly 10 pixels, no duplicates.
- Degenerate: collinear (0,0),(2,2),(4,4) → 0 pixels; o_done 2 cycles after accept.
- Off-screen: all vertex x in [-10,-2] → 0 pixels; o_done 2 cycles after accept. Clamp: v=(60,0),(100,0),(60,40) → no o_pixel_x>63, row 0 emits x=60..63.
- Winding: v1/v3 swapped from the first scenario → identical 10-pixel sequence.
- Reset: assert i_reset_n=0 after 3 pixels emitted → o_pixel_valid=0 and o_busy=0 asynchronously, no o_done; after release, a new triangle is accepted and emitted normally.

Source files
------------

// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: walks the screen-clamped bounding box of one triangle in row-major
// order and emits every pixel whose centre lies inside it (edge-inclusive, either winding).

package triangle_rasterizer_pkg;
    typedef logic signed [31:0] FixedPoint_t;
    typedef struct packed {
        FixedPoint_t x;
        FixedPoint_t y;
        FixedPoint_t z;
        FixedPoint_t w;
    } Vector4_t;
endpackage

module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_W   = 64,
    parameter int SCREEN_H   = 64,
    parameter int COORD_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_tri_valid,
    output logic                  o_tri_ready,
    input  Vector4_t              i_v1,
    input  Vector4_t              i_v2,
    input  Vector4_t              i_v3,
    output logic                  o_pixel_valid,
    input  logic                  i_pixel_ready,
    output logic [COORD_BITS-1:0] o_pixel_x,
    output logic [COORD_BITS-1:0] o_pixel_y,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} State_t;

    State_t                r_state;
    FixedPoint_t           r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic [COORD_BITS-1:0] r_x, r_y, r_xMin, r_xMax, r_yMax;
    logic                  r_triReady, r_busy, r_done;

    function automatic FixedPoint_t min3(input FixedPoint_t a, input FixedPoint_t b, input FixedPoint_t c);
        FixedPoint_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic FixedPoint_t max3(input FixedPoint_t a, input FixedPoint_t b, input FixedPoint_t c);
        FixedPoint_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Floor to whole pixels, then clamp to the screen on one side only; an off-screen
    // triangle then shows up as min > max.
    function automatic FixedPoint_t clampLo(input FixedPoint_t v);
        FixedPoint_t f;
        f = v >>> 16;
        return (f < 0) ? 32'sd0 : f;
    endfunction

    function automatic FixedPoint_t clampHi(input FixedPoint_t v, input int lim);
        FixedPoint_t f;
        f = v >>> 16;
        return (f > lim) ? FixedPoint_t'(lim) : f;
    endfunction

    function automatic logic signed [66:0] edgeFn(input FixedPoint_t ax, input FixedPoint_t ay,
                                                 input FixedPoint_t bx, input FixedPoint_t by,
                                                 input FixedPoint_t px, input FixedPoint_t py);
        logic signed [32:0] dx, dy, qx, qy;
        logic signed [66:0] p1, p2;
        dx = 33'(bx) - 33'(ax);
        dy = 33'(by) - 33'(ay);
        qx = 33'(px) - 33'(ax);
        qy = 33'(py) - 33'(ay);
        p1 = 67'(dx) * 67'(qy);
        p2 = 67'(dy) * 67'(qx);
        return p1 - p2;
    endfunction

    FixedPoint_t        w_xLo, w_xHi, w_yLo, w_yHi, w_px, w_py;
    logic signed [66:0] w_area, w_e1, w_e2, w_e3;
    logic               w_empty, w_inside, w_advance;
    logic               w_unused;

    assign w_xLo = clampLo(min3(r_ax, r_bx, r_cx));
    assign w_xHi = clampHi(max3(r_ax, r_bx, r_cx), SCREEN_W - 1);
    assign w_yLo = clampLo(min3(r_ay, r_by, r_cy));
    assign w_yHi = clampHi(max3(r_ay, r_by, r_cy), SCREEN_H - 1);

    // Edge v1->v2 evaluated at v3 is exactly the negated signed area, so it doubles as the area test.
    assign w_area  = edgeFn(r_ax, r_ay, r_bx, r_by, r_cx, r_cy);
    assign w_empty = (w_area == 0) || (w_xLo > w_xHi) || (w_yLo > w_yHi);

    assign w_px = 32'({r_x, 16'h8000});
    assign w_py = 32'({r_y, 16'h8000});
    assign w_e1 = edgeFn(r_ax, r_ay, r_bx, r_by, w_px, w_py);
    assign w_e2 = edgeFn(r_bx, r_by, r_cx, r_cy, w_px, w_py);
    assign w_e3 = edgeFn(r_cx, r_cy, r_ax, r_ay, w_px, w_py);

    assign w_inside  = ((w_e1 >= 0) && (w_e2 >= 0) && (w_e3 >= 0)) ||
                       ((w_e1 <= 0) && (w_e2 <= 0) && (w_e3 <= 0));
    assign w_advance = !w_inside || i_pixel_ready;

    assign w_unused = ^{i_v1.z, i_v1.w, i_v2.z, i_v2.w, i_v3.z, i_v3.w};

    assign o_pixel_valid = (r_state == SCAN) && w_inside;
    assign o_pixel_x     = r_x;
    assign o_pixel_y     = r_y;
    assign o_tri_ready   = r_triReady;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_triReady <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_xMin     <= '0;
            r_xMax     <= '0;
            r_yMax     <= '0;
            r_ax       <= '0;
            r_ay       <= '0;
            r_bx       <= '0;
            r_by       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_triReady <= 1'b1;
                    if (i_tri_valid && r_triReady) begin
                        r_ax       <= i_v1.x;
                        r_ay       <= i_v1.y;
                        r_bx       <= i_v2.x;
                        r_by       <= i_v2.y;
                        r_cx       <= i_v3.x;
                        r_cy       <= i_v3.y;
                        r_triReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_xMin  <= COORD_BITS'(w_xLo);
                        r_xMax  <= COORD_BITS'(w_xHi);
                        r_yMax  <= COORD_BITS'(w_yHi);
                        r_x     <= COORD_BITS'(w_xLo);
                        r_y     <= COORD_BITS'(w_yLo);
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_advance) begin
                        if (r_x == r_xMax) begin
                            if (r_y == r_yMax) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_x <= r_xMin;
                                r_y <= r_y + COORD_BITS'(1);
                            end
                        end else begin
                            r_x <= r_x + COORD_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    r_busy     <= 1'b0;
                    r_triReady <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Bench for triangle_rasterizer: directed vector table with hand-derived results, random
// triangles against an arithmetic coverage model, and a mid-triangle reset sequence.
`timescale 1ns/1ps
module tb_triangle_rasterizer;
    import triangle_rasterizer_pkg::*;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int CB = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } Pix_t;

    typedef struct {
        string name;
        int    ax, ay, bx, by, cx, cy;
        int    mode;
        int    expCount;
        int    expLat;
        int    handKind;
    } Vec_t;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          triValid = 1'b0;
    logic          triReady;
    Vector4_t      v1, v2, v3;
    logic          pixValid;
    logic          pixReady = 1'b0;
    logic [CB-1:0] pixX, pixY;
    logic          busy, done;

    triangle_rasterizer #(.SCREEN_W(W), .SCREEN_H(H), .COORD_BITS(CB)) dut (
        .i_clk(clk), .i_reset_n(rstN), .i_tri_valid(triValid), .o_tri_ready(triReady),
        .i_v1(v1), .i_v2(v2), .i_v3(v3), .o_pixel_valid(pixValid), .i_pixel_ready(pixReady),
        .o_pixel_x(pixX), .o_pixel_y(pixY), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int   nChecks = 0, nPassed = 0;
    int   readyMode = 0;
    int   cycleCnt = 0, validCnt = 0, stallCnt = 0, stallBad = 0, doneCnt = 0, doneCycle = 0;
    int   gotBase, doneBase, validBase, stallBase, stallBadBase, acceptCycle;
    Pix_t gotQ[$];
    Pix_t expQ[$];
    Vec_t vecs[6];
    int   handX[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    int   handY[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

    // Observe the handshake on the falling edge, half a cycle clear of the DUT's updates.
    always @(negedge clk) begin
        cycleCnt++;
        if (pixValid && pixReady) gotQ.push_back(Pix_t'({pixX, pixY}));
        if (pixValid) validCnt++;
        if (pixValid && !pixReady) begin
            stallCnt++;
            if (pixX != 0 || pixY != 0) stallBad++;
        end
        if (done) begin
            doneCnt++;
            doneCycle = cycleCnt;
        end
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       pixReady = 1'b1;
            1:       pixReady = ((validCnt - validBase) >= 5);
            default: pixReady = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input bit ok, input string name, input string detail);
        nChecks++;
        if (ok) nPassed++;
        else $display("[TB] FAIL %s: %s", name, detail);
    endtask

    function automatic int FX(input int n);
        return n * 65536;
    endfunction

    function automatic longint floorPix(input longint v);
        return (v >= 0) ? v / 65536 : -((-v + 65535) / 65536);
    endfunction

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    function automatic longint edgeVal(input longint ax, input longint ay, input longint bx,
                                       input longint by, input longint px, input longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // Reference: every on-screen pixel of the bounding box whose centre is inside or on the triangle.
    task automatic buildExpected(input longint ax, input longint ay, input longint bx,
                                 input longint by, input longint cx, input longint cy);
        longint area, xl, xh, yl, yh, px, py, e1, e2, e3;
        expQ.delete();
        area = (ax - bx) * (cy - ay) - (ay - by) * (cx - ax);
        if (area == 0) return;
        xl = lmax(floorPix(lmin(ax, lmin(bx, cx))), 0);
        xh = lmin(floorPix(lmax(ax, lmax(bx, cx))), W - 1);
        yl = lmax(floorPix(lmin(ay, lmin(by, cy))), 0);
        yh = lmin(floorPix(lmax(ay, lmax(by, cy))), H - 1);
        for (longint y = yl; y <= yh; y++) begin
            for (longint x = xl; x <= xh; x++) begin
                px = x * 65536 + 32768;
                py = y * 65536 + 32768;
                e1 = edgeVal(ax, ay, bx, by, px, py);
                e2 = edgeVal(bx, by, cx, cy, px, py);
                e3 = edgeVal(cx, cy, ax, ay, px, py);
                if ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0))
                    expQ.push_back(Pix_t'({8'(x), 8'(y)}));
            end
        end
    endtask

    task automatic applyStimulus(input Vec_t t, output bit accepted);
        int n = 0;
        readyMode = t.mode;
        @(negedge clk); #1;
        while (!triReady && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        accepted = triReady;
        checkOutput(accepted, {t.name, "_accept"}, $sformatf("tri_ready=%0b after %0d cycles, required 1", triReady, n));
        if (!accepted) return;
        gotBase      = gotQ.size();
        doneBase     = doneCnt;
        validBase    = validCnt;
        stallBase    = stallCnt;
        stallBadBase = stallBad;
        acceptCycle  = cycleCnt;
        v1 = '{x: t.ax, y: t.ay, z: $urandom, w: $urandom};
        v2 = '{x: t.bx, y: t.by, z: $urandom, w: $urandom};
        v3 = '{x: t.cx, y: t.cy, z: $urandom, w: $urandom};
        triValid = 1'b1;
        @(posedge clk); #1;
        triValid = 1'b0;
    endtask

    task automatic runVector(input Vec_t t);
        bit   accepted;
        int   n, mis, maxX;
        bit   ok;
        Pix_t g, e;
        applyStimulus(t, accepted);
        if (!accepted) return;
        buildExpected(t.ax, t.ay, t.bx, t.by, t.cx, t.cy);
        n = 0;
        while (doneCnt == doneBase && n < 20000) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(doneCnt != doneBase, {t.name, "_done"}, $sformatf("no o_done after %0d cycles, required a pulse", n));
        if (t.expLat >= 0)
            checkOutput(doneCycle - acceptCycle == t.expLat, {t.name, "_done_latency"},
                        $sformatf("o_done %0d cycles after accept, required %0d", doneCycle - acceptCycle, t.expLat));
        @(negedge clk); #1;
        checkOutput(triReady === 1'b1, {t.name, "_ready_after_done"}, $sformatf("tri_ready=%0b, required 1", triReady));
        repeat (3) @(negedge clk);
        #1;
        checkOutput(doneCnt - doneBase == 1, {t.name, "_done_once"}, $sformatf("%0d o_done pulses, required 1", doneCnt - doneBase));

        n = gotQ.size() - gotBase;
        if (t.expCount >= 0)
            checkOutput(n == t.expCount, {t.name, "_count"}, $sformatf("%0d pixels, required %0d", n, t.expCount));
        checkOutput(n == expQ.size(), {t.name, "_model_count"}, $sformatf("%0d pixels, model requires %0d", n, expQ.size()));
        mis = -1;
        for (int i = 0; i < n && i < expQ.size(); i++)
            if (mis < 0 && gotQ[gotBase + i] != expQ[i]) mis = i;
        if (mis >= 0) begin
            g = gotQ[gotBase + mis];
            e = expQ[mis];
        end
        checkOutput(mis < 0, {t.name, "_model_seq"},
                    $sformatf("pixel %0d is (%0d,%0d), model requires (%0d,%0d)", mis, g.x, g.y, e.x, e.y));
        maxX = 0;
        for (int i = 0; i < n; i++) if (gotQ[gotBase + i].x > maxX) maxX = gotQ[gotBase + i].x;
        checkOutput(maxX <= W - 1, {t.name, "_x_on_screen"}, $sformatf("max x %0d, required <= %0d", maxX, W - 1));

        if (t.handKind == 1) begin
            ok = (n == 10);
            for (int i = 0; i < 10 && i < n; i++)
                if (gotQ[gotBase + i].x != handX[i] || gotQ[gotBase + i].y != handY[i]) ok = 0;
            checkOutput(ok, {t.name, "_hand_seq"}, $sformatf("%0d pixels, first (%0d,%0d); required the 10-pixel list from (0,0)",
                        n, (n > 0) ? gotQ[gotBase].x : 0, (n > 0) ? gotQ[gotBase].y : 0));
        end else if (t.handKind == 2) begin
            ok = (n >= 4);
            for (int i = 0; i < 4 && i < n; i++)
                if (gotQ[gotBase + i].x != 60 + i || gotQ[gotBase + i].y != 0) ok = 0;
            checkOutput(ok, {t.name, "_row0"}, $sformatf("%0d pixels, first (%0d,%0d); required row 0 x=60..63",
                        n, (n > 0) ? gotQ[gotBase].x : 0, (n > 0) ? gotQ[gotBase].y : 0));
        end
        if (t.mode == 1) begin
            checkOutput(stallCnt - stallBase == 5, {t.name, "_stall_cycles"}, $sformatf("%0d stalled cycles, required 5", stallCnt - stallBase));
            checkOutput(stallBad == stallBadBase, {t.name, "_stall_stable"}, $sformatf("%0d stalled cycles not at (0,0), required 0", stallBad - stallBadBase));
        end
    endtask

    initial begin
        Vec_t rv;
        bit   accepted;
        int   n, frac;

        vecs[0] = '{"coverage",     FX(0),   FX(0),  FX(4),  FX(0), FX(0),   FX(4),  0, 10,  27,  1};
        vecs[1] = '{"backpressure", FX(0),   FX(0),  FX(4),  FX(0), FX(0),   FX(4),  1, 10,  32,  1};
        vecs[2] = '{"degenerate",   FX(0),   FX(0),  FX(2),  FX(2), FX(4),   FX(4),  0, 0,   2,   0};
        vecs[3] = '{"offscreen",    FX(-10), FX(0),  FX(-2), FX(0), FX(-10), FX(8),  0, 0,   2,   0};
        vecs[4] = '{"clamp",        FX(60),  FX(0),  FX(100), FX(0), FX(60), FX(40), 0, 154, 166, 2};
        vecs[5] = '{"winding",      FX(0),   FX(4),  FX(4),  FX(0), FX(0),   FX(0),  0, 10,  27,  1};
        v1 = '0;
        v2 = '0;
        v3 = '0;

        #2;
        checkOutput(triReady === 1'b0, "reset_tri_ready", $sformatf("%0b, required 0", triReady));
        checkOutput(pixValid === 1'b0, "reset_pixel_valid", $sformatf("%0b, required 0", pixValid));
        checkOutput(busy === 1'b0, "reset_busy", $sformatf("%0b, required 0", busy));
        checkOutput(done === 1'b0, "reset_done", $sformatf("%0b, required 0", done));
        checkOutput(pixX === 0 && pixY === 0, "reset_xy", $sformatf("(%0d,%0d), required (0,0)", pixX, pixY));
        #10 rstN = 1'b1;
        @(negedge clk); #1;
        checkOutput(triReady === 1'b1, "release_tri_ready", $sformatf("%0b, required 1", triReady));

        for (int i = 0; i < 6; i++) runVector(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            frac = (i % 2 == 0) ? 0 : -1;
            rv.name = $sformatf("random%0d", i);
            rv.ax = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.ay = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.bx = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.by = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.cx = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.cy = (frac == 0) ? FX($urandom_range(0, 44) - 4) + 32768 : int'($urandom_range(0, 44 * 65536)) - FX(4);
            rv.mode = 2;
            rv.expCount = -1;
            rv.expLat = -1;
            rv.handKind = 0;
            runVector(rv);
        end

        // Mid-triangle reset: abandon after three pixels, then a clean triangle must still work.
        applyStimulus(vecs[0], accepted);
        if (accepted) begin
            n = 0;
            while (gotQ.size() - gotBase < 3 && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            checkOutput(gotQ.size() - gotBase >= 3, "reset_mid_pixels", $sformatf("%0d pixels before reset, required 3", gotQ.size() - gotBase));
            #1 rstN = 1'b0;
            #1;
            checkOutput(pixValid === 1'b0, "reset_mid_pixel_valid", $sformatf("%0b, required 0", pixValid));
            checkOutput(busy === 1'b0, "reset_mid_busy", $sformatf("%0b, required 0", busy));
            checkOutput(triReady === 1'b0, "reset_mid_tri_ready", $sformatf("%0b, required 0", triReady));
            repeat (3) @(negedge clk);
            #1;
            checkOutput(doneCnt == doneBase, "reset_mid_no_done", $sformatf("%0d o_done pulses, required 0", doneCnt - doneBase));
            checkOutput(pixX === 0 && pixY === 0, "reset_mid_xy", $sformatf("(%0d,%0d), required (0,0)", pixX, pixY));
            rstN = 1'b1;
        end
        runVector(vecs[0]);

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
